ledger_line_renderer: RTL and testbench

//  Parametrised, pipelined successor to the fixed 8x8 ledger-line glyph ROM.

---
 rtl/ledger_line_renderer.sv | 163 ++++++++++++++++
 tb/tb_ledger_line_renderer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ledger_line_renderer.sv
// Ledger-line glyph renderer: a small note table tested against every VGA pixel
// in a two-stage pipeline, with optional blinking of one selected note.
module ledger_line_renderer #(
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 8,
    parameter int NUM_NOTES    = 8,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int BLINK_FRAMES = 30,
    localparam int IDX_W       = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [1:0]       wr_code,
    input  logic             clear_all,
    input  logic             pix_valid,
    input  logic [X_W-1:0]   DrawX,
    input  logic [Y_W-1:0]   DrawY,
    input  logic             frame_start,
    input  logic             blink_en,
    input  logic [IDX_W-1:0] sel_idx,
    output logic             out_valid,
    output logic             pixel_on,
    output logic [IDX_W-1:0] hit_idx,
    output logic             hit
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [1:0] CODE_BLANK  = 2'd0;
    localparam logic [1:0] CODE_MIDDLE = 2'd1;
    localparam logic [1:0] CODE_ABOVE  = 2'd2;
    localparam logic [1:0] CODE_BELOW  = 2'd3;

    logic           ent_valid [NUM_NOTES];
    logic [X_W-1:0] ent_x     [NUM_NOTES];
    logic [Y_W-1:0] ent_y     [NUM_NOTES];
    logic [1:0]     ent_code  [NUM_NOTES];

    logic wr_ok;
    assign wr_ok = (int'(wr_idx) < NUM_NOTES);

    // Pixel handshake: pix_valid qualifies DrawX/DrawY in its cycle; out_valid
    // is the same flag two clocks later and qualifies pixel_on/hit/hit_idx.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                ent_valid[i] <= 1'b0;
                ent_x[i]     <= '0;
                ent_y[i]     <= '0;
                ent_code[i]  <= CODE_BLANK;
            end
        end else if (clear_all) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                ent_valid[i] <= 1'b0;
            end
        end else if (wr_en && wr_ok) begin
            ent_valid[wr_idx] <= 1'b1;
            ent_x[wr_idx]     <= wr_x;
            ent_y[wr_idx]     <= wr_y;
            ent_code[wr_idx]  <= wr_code;
        end
    end

    // Stage 1 search: box bounds are widened by one bit so boxes at the screen edge do not wrap.
    logic             c_hit;
    logic [IDX_W-1:0] c_idx;
    logic [1:0]       c_code;
    logic [Y_W-1:0]   c_row;

    always_comb begin
        c_hit  = 1'b0;
        c_idx  = '0;
        c_code = CODE_BLANK;
        c_row  = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_code[i] != CODE_BLANK) &&
                ({1'b0, DrawX} >= {1'b0, ent_x[i]}) &&
                ({1'b0, DrawX} <  ({1'b0, ent_x[i]} + (X_W+1)'(GLYPH_W))) &&
                ({1'b0, DrawY} >= {1'b0, ent_y[i]}) &&
                ({1'b0, DrawY} <  ({1'b0, ent_y[i]} + (Y_W+1)'(GLYPH_H)))) begin
                c_hit  = 1'b1;
                c_idx  = IDX_W'(i);
                c_code = ent_code[i];
                c_row  = DrawY - ent_y[i];
            end
        end
    end

    logic             s1_valid;
    logic             s1_hit;
    logic [IDX_W-1:0] s1_idx;
    logic [1:0]       s1_code;
    logic [Y_W-1:0]   s1_row;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_idx   <= '0;
            s1_code  <= CODE_BLANK;
            s1_row   <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_hit   <= pix_valid && c_hit;
            s1_idx   <= c_idx;
            s1_code  <= c_code;
            s1_row   <= c_row;
        end
    end

    logic [CNT_W-1:0] frame_cnt;
    logic             blink_phase;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    logic lit;
    logic blanked;

    always_comb begin
        lit = 1'b0;
        case (s1_code)
            CODE_MIDDLE: lit = (s1_row == Y_W'(GLYPH_H / 2));
            CODE_ABOVE:  lit = (s1_row == '0);
            CODE_BELOW:  lit = (s1_row == Y_W'(GLYPH_H - 1));
            default:     lit = 1'b0;
        endcase
        blanked = blink_en && blink_phase && (s1_idx == sel_idx);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            pixel_on  <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            hit       <= s1_hit;
            hit_idx   <= s1_hit ? s1_idx : '0;
            pixel_on  <= s1_hit && lit && !blanked;
        end
    end

endmodule

// File: tb/tb_ledger_line_renderer.sv
// Directed bench for ledger_line_renderer: pixels stream one per cycle and each
// expected {out_valid, pixel_on, hit, hit_idx} is checked two cycles later.
module tb_ledger_line_renderer;

    logic       Clk;
    logic       Reset;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [1:0] wr_code;
    logic       clear_all;
    logic       pix_valid;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       frame_start;
    logic       blink_en;
    logic [2:0] sel_idx;
    logic       out_valid;
    logic       pixel_on;
    logic [2:0] hit_idx;
    logic       hit;

    int n_checks;
    int n_errors;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    ledger_line_renderer #(
        .GLYPH_W(8), .GLYPH_H(8), .NUM_NOTES(8),
        .X_W(10), .Y_W(10), .BLINK_FRAMES(2)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_code(wr_code),
        .clear_all(clear_all),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .blink_en(blink_en), .sel_idx(sel_idx),
        .out_valid(out_valid), .pixel_on(pixel_on), .hit_idx(hit_idx), .hit(hit)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected output word {out_valid, pixel_on, hit, hit_idx}
    function automatic logic [5:0] ev(input logic on, input logic h, input logic [2:0] idx);
        return {1'b1, on, h, idx};
    endfunction

    // One clock: compare the result of the pixel driven two ticks ago, then
    // drive this tick's pixel. Write/clear/frame strobes set by the caller
    // are dropped after the edge.
    task automatic tick(input logic pv, input logic [9:0] x, input logic [9:0] y,
                        input logic [5:0] exp, input string tag);
        if (exp_q.size() >= 2)
            check(tag_q.pop_front(), {26'd0, out_valid, pixel_on, hit, hit_idx}, {26'd0, exp_q.pop_front()});
        pix_valid = pv;
        DrawX     = x;
        DrawY     = y;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        wr_en       = 1'b0;
        clear_all   = 1'b0;
        frame_start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic idle();
        tick(1'b0, 10'd0, 10'd0, 6'd0, "idle");
    endtask

    task automatic write(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                         input logic [1:0] code);
        wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_code = code;
        idle();
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        idle();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        Reset = 1'b1;
        wr_en = 0; wr_idx = 0; wr_x = 0; wr_y = 0; wr_code = 0; clear_all = 0;
        pix_valid = 0; DrawX = 0; DrawY = 0; frame_start = 0; blink_en = 0; sel_idx = 0;
        repeat (3) @(negedge Clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pixel_on",  {31'd0, pixel_on},  32'd0);
        check("rst_hit",       {31'd0, hit},       32'd0);
        check("rst_hit_idx",   {29'd0, hit_idx},   32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // MIDDLE glyph at (100,50): lit row is 54
        write(3'd0, 10'd100, 10'd50, 2'd1);
        for (int x = 100; x < 108; x++)
            tick(1'b1, 10'(x), 10'd54, ev(1, 1, 0), "mid_row54");
        tick(1'b1, 10'd100, 10'd53, ev(0, 1, 0), "mid_row53");
        tick(1'b1, 10'd107, 10'd55, ev(0, 1, 0), "mid_row55");
        tick(1'b1, 10'd108, 10'd54, ev(0, 0, 0), "mid_right_edge");
        tick(1'b1, 10'd99,  10'd54, ev(0, 0, 0), "mid_left_edge");
        tick(1'b1, 10'd100, 10'd58, ev(0, 0, 0), "mid_bottom_edge");
        idle();

        // priority between overlapping ABOVE (idx2) and BELOW (idx3)
        write(3'd2, 10'd20, 10'd30, 2'd2);
        write(3'd3, 10'd20, 10'd30, 2'd3);
        tick(1'b1, 10'd20, 10'd30, ev(1, 1, 2), "above_top");
        tick(1'b1, 10'd20, 10'd37, ev(0, 1, 2), "prio_idx2");
        write(3'd2, 10'd20, 10'd30, 2'd0);
        tick(1'b1, 10'd20, 10'd37, ev(1, 1, 3), "below_bottom");
        tick(1'b1, 10'd20, 10'd30, ev(0, 1, 3), "below_top_unlit");

        // box at the right screen edge must not wrap to x=0
        write(3'd1, 10'd1020, 10'd0, 2'd2);
        for (int x = 1020; x < 1024; x++)
            tick(1'b1, 10'(x), 10'd0, ev(1, 1, 1), "edge_lit");
        for (int x = 0; x < 4; x++)
            tick(1'b1, 10'(x), 10'd0, ev(0, 0, 0), "edge_nowrap");

        // write and pixel in the same cycle: pixel still sees the old entry
        wr_en = 1'b1; wr_idx = 3'd0; wr_x = 10'd200; wr_y = 10'd50; wr_code = 2'd1;
        tick(1'b1, 10'd100, 10'd54, ev(1, 1, 0), "same_cycle_old");
        tick(1'b1, 10'd100, 10'd54, ev(0, 0, 0), "next_cycle_old_gone");
        tick(1'b1, 10'd200, 10'd54, ev(1, 1, 0), "next_cycle_new");
        idle();

        // blink idx0 with two frames per half-period
        blink_en = 1'b1; sel_idx = 3'd0;
        idle();
        tick(1'b1, 10'd200, 10'd54, ev(1, 1, 0), "blink_phase0");
        idle();
        pulse(); pulse();
        tick(1'b1, 10'd200, 10'd54, ev(0, 1, 0), "blink_off_2");
        tick(1'b1, 10'd20,  10'd37, ev(1, 1, 3), "blink_other_note");
        idle();
        pulse();
        tick(1'b1, 10'd200, 10'd54, ev(0, 1, 0), "blink_off_3");
        idle();
        pulse();
        tick(1'b1, 10'd200, 10'd54, ev(1, 1, 0), "blink_on_4");
        idle();
        pulse(); pulse();
        tick(1'b1, 10'd200, 10'd54, ev(0, 1, 0), "blink_off_6");
        idle();
        blink_en = 1'b0;
        tick(1'b1, 10'd200, 10'd54, ev(1, 1, 0), "blink_disabled");
        idle();

        // clear_all beats a same-cycle write
        clear_all = 1'b1;
        wr_en = 1'b1; wr_idx = 3'd0; wr_x = 10'd200; wr_y = 10'd50; wr_code = 2'd1;
        idle();
        tick(1'b1, 10'd200,  10'd54, ev(0, 0, 0), "clear_idx0");
        tick(1'b1, 10'd20,   10'd37, ev(0, 0, 0), "clear_idx3");
        tick(1'b1, 10'd1020, 10'd0,  ev(0, 0, 0), "clear_idx1");

        // asynchronous reset in the middle of a scan
        write(3'd5, 10'd300, 10'd300, 2'd1);
        tick(1'b1, 10'd300, 10'd304, ev(1, 1, 5), "pre_rst_a");
        tick(1'b1, 10'd301, 10'd304, ev(1, 1, 5), "pre_rst_b");
        tick(1'b1, 10'd302, 10'd304, ev(1, 1, 5), "pre_rst_c");
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        Reset = 1'b1;
        #1;
        check("rst_async_valid", {31'd0, out_valid}, 32'd0);
        check("rst_async_on",    {31'd0, pixel_on},  32'd0);
        check("rst_async_hit",   {31'd0, hit},       32'd0);
        exp_q.delete();
        tag_q.delete();
        pix_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        tick(1'b1, 10'd300, 10'd304, ev(0, 0, 0), "post_rst_table_empty");
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
